// File: rtl/fm_mod.sv
// FM modulator: phase accumulator driven by audio plus carrier offset, with I/Q
// produced by time-multiplexing one registered quarter-wave sine ROM.
module fm_mod #(
    parameter int BITS_IN    = 16,
    parameter int BITS_OUT   = 5,
    parameter int PHASE_BITS = 16,
    parameter int LUT_BITS   = 6,
    parameter int DEV_SHIFT  = 0
) (
    input  logic                       CLK,
    input  logic                       RSTb,
    input  logic signed [BITS_IN-1:0]  audio_in,
    input  logic [PHASE_BITS-1:0]      freq_offset,
    input  logic                       load_tick,
    output logic signed [BITS_OUT-1:0] I_out,
    output logic signed [BITS_OUT-1:0] Q_out,
    output logic                       out_tick,
    output logic                       overrun
);

    localparam int N   = 1 << LUT_BITS;
    localparam int AMP = (1 << (BITS_OUT - 1)) - 1;

    typedef enum logic [2:0] {IDLE, ACC, RD_S, RD_C, FIN} state_t;

    function automatic int rom_entry(input int k);
        real ang;
        ang = 3.14159265358979 / 2.0 * (real'(k) + 0.5) / real'(N);
        return $rtoi(real'(AMP) * $sin(ang) + 0.5);
    endfunction

    function automatic logic signed [BITS_OUT-1:0] fold(input logic [BITS_OUT-2:0] mag,
                                                        input logic neg);
        logic signed [BITS_OUT-1:0] ext;
        ext = {1'b0, mag};
        return neg ? -ext : ext;
    endfunction

    logic [BITS_OUT-2:0] rom_table [N];

    for (genvar g = 0; g < N; g++) begin : g_rom
        localparam int VAL = rom_entry(g);
        assign rom_table[g] = VAL[BITS_OUT-2:0];
    end

    state_t                       state_r, state_n;
    logic signed [BITS_IN-1:0]    audio_r;
    logic [PHASE_BITS-1:0]        offset_r;
    logic [PHASE_BITS-1:0]        phase_r;
    logic [BITS_OUT-2:0]          rom_data_r;
    logic signed [BITS_OUT-1:0]   sin_r;
    logic signed [BITS_OUT-1:0]   i_out_r;
    logic signed [BITS_OUT-1:0]   q_out_r;
    logic                         out_tick_r;
    logic                         overrun_r;

    logic                         accept_s;
    logic [LUT_BITS-1:0]          rom_addr_s;
    logic signed [PHASE_BITS-1:0] audio_ext_s;
    logic signed [PHASE_BITS-1:0] dev_s;
    logic [PHASE_BITS-1:0]        inc_s;
    logic [1:0]                   q_sin_s;
    logic [1:0]                   q_cos_s;
    logic [LUT_BITS-1:0]          k_s;

    // Shift kept separate so the offset add cannot turn >>> into a logical shift.
    assign audio_ext_s = PHASE_BITS'(audio_r);
    assign dev_s       = audio_ext_s >>> DEV_SHIFT;
    assign inc_s       = dev_s + offset_r;

    // Cos is sin a quarter turn later: only the quadrant changes, k is shared.
    assign q_sin_s = phase_r[PHASE_BITS-1 -: 2];
    assign q_cos_s = q_sin_s + 2'd1;
    assign k_s     = phase_r[PHASE_BITS-3 -: LUT_BITS];

    // FSM state register.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_n;
        end
    end

    // Next-state, sample acceptance and ROM address selection.
    always_comb begin
        state_n    = state_r;
        accept_s   = 1'b0;
        rom_addr_s = k_s;
        case (state_r)
            IDLE: begin
                if (load_tick) begin
                    accept_s = 1'b1;
                    state_n  = ACC;
                end else begin
                    state_n  = IDLE;
                end
            end
            ACC:  state_n = RD_S;
            RD_S: begin
                rom_addr_s = q_sin_s[0] ? ~k_s : k_s;
                state_n    = RD_C;
            end
            RD_C: begin
                rom_addr_s = q_cos_s[0] ? ~k_s : k_s;
                state_n    = FIN;
            end
            FIN:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Registered ROM read, one cycle latency.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            rom_data_r <= '0;
        end else begin
            rom_data_r <= rom_table[rom_addr_s];
        end
    end

    // Sample latch, phase accumulation, sign folding and output registers.
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            audio_r    <= '0;
            offset_r   <= '0;
            phase_r    <= '0;
            sin_r      <= '0;
            i_out_r    <= '0;
            q_out_r    <= '0;
            out_tick_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            if (accept_s) begin
                audio_r  <= audio_in;
                offset_r <= freq_offset;
            end
            if (state_r == ACC) begin
                phase_r <= phase_r + inc_s;
            end
            if (state_r == RD_C) begin
                sin_r <= fold(rom_data_r, q_sin_s[1]);
            end
            if (state_r == FIN) begin
                i_out_r <= fold(rom_data_r, q_cos_s[1]);
                q_out_r <= sin_r;
            end
            out_tick_r <= (state_r == FIN);
            if (load_tick && (state_r != IDLE)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign I_out    = i_out_r;
    assign Q_out    = q_out_r;
    assign out_tick = out_tick_r;
    assign overrun  = overrun_r;

endmodule

// File: doc/fm_mod.md
Name: fm_mod

Overview:
- FM modulator: the transmit-side counterpart of the FM demodulator.
- Takes one signed baseband audio sample per load_tick and adds a scaled frequency increment to a wrapping phase accumulator.
- Produces a quantised complex baseband sample (I = cos, Q = sin) through a shared quarter-wave sine ROM.
- Feeds the upconverter/DAC path or loops back into the receive chain for self-test. Default BITS_OUT matches the demodulator's 5-bit I/Q input.

Parameters:
- BITS_IN, 16, width of signed audio input.
- BITS_OUT, 5, width of signed I/Q outputs; peak amplitude A = 2^(BITS_OUT-1)-1 (15 at default).
- PHASE_BITS, 16, phase accumulator width; must be >= BITS_IN and >= LUT_BITS+2.
- LUT_BITS, 6, quarter-wave ROM address width (N = 2^LUT_BITS entries).
- DEV_SHIFT, 0, arithmetic right shift applied to the audio-derived increment (sets deviation).

Ports:
- CLK  input  1  system clock; all logic on its rising edge.
- RSTb  input  1  asynchronous active-low reset.
- audio_in  input  BITS_IN  signed audio sample; sampled only when load_tick is accepted.
- freq_offset  input  PHASE_BITS  unsigned carrier offset increment added every sample; sampled with audio_in.
- load_tick  input  1  single-cycle pulse; a new sample is present.
- I_out  output  BITS_OUT  signed cos(phase), registered.
- Q_out  output  BITS_OUT  signed sin(phase), registered.
- out_tick  output  1  single-cycle pulse; I_out/Q_out were just updated.
- overrun  output  1  sticky flag; a load_tick arrived while busy. Cleared only by reset.

Behaviour:
- Reset (RSTb low, asynchronous):
  - phase = 0, I_out = 0, Q_out = 0, out_tick = 0, overrun = 0, state = IDLE.
  - Reset mid-operation aborts the operation; no out_tick is produced for the aborted sample.
- ROM contents: registered read, 1-cycle latency. T[k] = round(A * sin(pi/2 * (k+0.5)/N)), k = 0..N-1. Unsigned values 0..A.
- Increment: inc = sign_extend(audio_in to PHASE_BITS) >>> DEV_SHIFT, then + freq_offset. Sum is taken modulo 2^PHASE_BITS. The phase accumulator wraps silently, with no saturation.
- Folding for phase p:
  - q = p[PHASE_BITS-1:PHASE_BITS-2], k = p[PHASE_BITS-3:PHASE_BITS-2-LUT_BITS]. Lower bits are truncated.
  - sin(p): q0 -> +T[k], q1 -> +T[N-1-k], q2 -> -T[k], q3 -> -T[N-1-k].
  - cos(p) = sin(p + 2^(PHASE_BITS-2)), computed by modulo add.
  - Negation is two's complement on BITS_OUT bits; the range -A..+A never overflows.
- FSM (one ROM, time-multiplexed), one state per clock:
  - IDLE: on load_tick, latch audio_in and freq_offset, go to ACC.
  - ACC: phase <= phase + inc; go to RD_S.
  - RD_S: issue the sin address; go to RD_C.
  - RD_C: capture and sign-fold the sin data; issue the cos address; go to FIN.
  - FIN: capture and fold the cos data. Load I_out <= cos and Q_out <= sin in the same cycle, assert out_tick for one cycle, go to IDLE.
- Latency: load_tick sampled at edge E; I_out/Q_out update and out_tick is high after edge E+4. The output reflects the phase after adding the current sample's increment.
- Throughput: one sample per 5 clocks.
  - load_tick in any state other than IDLE is dropped: no phase update, overrun <= 1.
  - load_tick on the same edge FSM returns to IDLE (i.e. while in FIN) is also dropped.
- I_out and Q_out hold their values between out_ticks. out_tick is low in all other cycles.

Test Plan:
- Reset -> I_out = 0, Q_out = 0, out_tick = 0, overrun = 0. Asserting RSTb mid-cycle (no clock edge) clears all outputs immediately.
- freq_offset = 0, audio_in = 0, one load_tick -> phase 0x0000; exactly 4 edges later out_tick = 1 for one cycle with I = 15, Q = 0.
- freq_offset = 0x4000, audio_in = 0, four ticks spaced 8 clocks apart -> (I,Q) = (0,15), (-15,0), (0,-15), (15,0); phase ends at 0x0000 (wrap).
- freq_offset = 0, audio_in = -16384 (0xC000), DEV_SHIFT = 0, two ticks -> phases 0xC000 then 0x8000; outputs (0,-15) then (-15,0).
- load_tick on two consecutive cycles -> one out_tick only, phase advanced once, overrun = 1 and stays 1 after further normal ticks until RSTb.
- RSTb pulsed low while in RD_C, then released -> no out_tick; the next tick with freq_offset = 0x4000 yields (0,15), proving the phase restarted at 0.
